// File: rtl/mux_key_with_default_if.sv
// Signal bundle for the key-lookup multiplexer: table, key and default in,
// combinational selection and its registered copy out.
interface mux_key_with_default_if #(
    parameter int NR_KEY   = 2,
    parameter int KEY_LEN  = 1,
    parameter int DATA_LEN = 1
);
    localparam int PAIR_LEN = KEY_LEN + DATA_LEN;
    localparam int IDX_W    = (NR_KEY > 1) ? $clog2(NR_KEY) : 1;

    logic [KEY_LEN-1:0]         key;
    logic [DATA_LEN-1:0]        default_out;
    logic [NR_KEY*PAIR_LEN-1:0] lut;
    logic                       en;
    logic [DATA_LEN-1:0]        out;
    logic                       hit;
    logic [IDX_W-1:0]           hit_idx;
    logic [DATA_LEN-1:0]        out_q;
    logic                       hit_q;
    logic [IDX_W-1:0]           idx_q;

    modport master (
        output key, default_out, lut, en,
        input  out, hit, hit_idx, out_q, hit_q, idx_q
    );

    modport slave (
        input  key, default_out, lut, en,
        output out, hit, hit_idx, out_q, hit_q, idx_q
    );
endinterface

// File: rtl/mux_key_with_default.sv
// Key-lookup multiplexer: highest-index matching {key,data} pair wins, else
// default_out. Zero-latency combinational result plus an enabled register copy.
module mux_key_with_default #(
    parameter int NR_KEY   = 2,
    parameter int KEY_LEN  = 1,
    parameter int DATA_LEN = 1
) (
    input logic                 clk,
    input logic                 rst,
    mux_key_with_default_if.slave bus
);
    localparam int PAIR_LEN = KEY_LEN + DATA_LEN;
    localparam int IDX_W    = (NR_KEY > 1) ? $clog2(NR_KEY) : 1;

    logic [DATA_LEN-1:0] sel_data;
    logic                sel_hit;
    logic [IDX_W-1:0]    sel_idx;

    // Ascending scan: a later (higher-index) match overwrites an earlier one,
    // so duplicates resolve to the highest index instead of OR-ing data.
    always_comb begin
        sel_data = bus.default_out;
        sel_hit  = 1'b0;
        sel_idx  = '0;
        for (int i = 0; i < NR_KEY; i++) begin
            if (bus.lut[PAIR_LEN*i+DATA_LEN +: KEY_LEN] == bus.key) begin
                sel_hit  = 1'b1;
                sel_idx  = IDX_W'(i);
                sel_data = bus.lut[PAIR_LEN*i +: DATA_LEN];
            end
        end
    end

    assign bus.out     = sel_data;
    assign bus.hit     = sel_hit;
    assign bus.hit_idx = sel_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_q <= '0;
            bus.hit_q <= 1'b0;
            bus.idx_q <= '0;
        end else if (bus.en) begin
            bus.out_q <= sel_data;
            bus.hit_q <= sel_hit;
            bus.idx_q <= sel_idx;
        end
    end
endmodule

// File: tb/tb_mux_key_with_default.sv
// Bench for mux_key_with_default: directed table cases, register path
// sequencing, single-pair corner, and a randomized run against a lookup model.
module tb_mux_key_with_default;
    logic clk = 1'b0;
    logic rst_a, rst_b, rst_c;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mux_key_with_default_if #(.NR_KEY(3), .KEY_LEN(7), .DATA_LEN(32)) ifa ();
    mux_key_with_default_if #(.NR_KEY(4), .KEY_LEN(3), .DATA_LEN(8))  ifb ();
    mux_key_with_default_if #(.NR_KEY(1), .KEY_LEN(2), .DATA_LEN(4))  ifc ();

    mux_key_with_default #(.NR_KEY(3), .KEY_LEN(7), .DATA_LEN(32)) dut_a (
        .clk(clk), .rst(rst_a), .bus(ifa));
    mux_key_with_default #(.NR_KEY(4), .KEY_LEN(3), .DATA_LEN(8)) dut_b (
        .clk(clk), .rst(rst_b), .bus(ifb));
    mux_key_with_default #(.NR_KEY(1), .KEY_LEN(2), .DATA_LEN(4)) dut_c (
        .clk(clk), .rst(rst_c), .bus(ifc));

    // scoreboard entries: {hit, idx[1:0], data[7:0]}
    logic [10:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: split the table into key/data arrays, search from the
    // highest index downward and return the first match.
    function automatic logic [10:0] model_b(input logic [43:0] lut, input logic [2:0] key,
                                            input logic [7:0] dflt);
        logic [2:0] keys[4];
        logic [7:0] datas[4];
        for (int i = 0; i < 4; i++) begin
            keys[i]  = lut[11*i+8 +: 3];
            datas[i] = lut[11*i +: 8];
        end
        for (int i = 3; i >= 0; i--)
            if (keys[i] == key) return {1'b1, 2'(i), datas[i]};
        return {1'b0, 2'b00, dflt};
    endfunction

    initial begin
        logic [10:0] m, reg_model, got;

        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        ifa.en = 1'b1; ifb.en = 1'b0; ifc.en = 1'b0;
        ifa.lut = {7'b0010111, 32'h8000_0000, 7'b0110111, 32'h0, 7'b1101111, 32'h8000_0000};
        ifa.default_out = 32'h1234_5678;
        ifa.key = 7'b0110111;
        ifb.lut = '0; ifb.key = '0; ifb.default_out = '0;
        ifc.lut = {2'b00, 4'h0}; ifc.key = 2'b00; ifc.default_out = 4'hA;

        // register path of table A under reset
        tick(); tick();
        check("a_rst_out_q", ifa.out_q, 0);
        check("a_rst_hit_q", ifa.hit_q, 0);
        check("a_rst_idx_q", ifa.idx_q, 0);
        check("b_rst_out_q", ifb.out_q, 0);
        check("b_rst_hit_q", ifb.hit_q, 0);

        // combinational table lookups
        check("a_k37_out", ifa.out, 0);
        check("a_k37_hit", ifa.hit, 1);
        check("a_k37_idx", ifa.hit_idx, 1);
        ifa.key = 7'b0010011; #1;
        check("a_miss_out", ifa.out, 32'h1234_5678);
        check("a_miss_hit", ifa.hit, 0);
        check("a_miss_idx", ifa.hit_idx, 0);
        ifa.key = 7'b0010111; #1;
        check("a_k17_idx", ifa.hit_idx, 2);
        check("a_k17_out", ifa.out, 32'h8000_0000);
        ifa.key = 7'b1101111; #1;
        check("a_k6f_idx", ifa.hit_idx, 0);
        check("a_k6f_out", ifa.out, 32'h8000_0000);

        // duplicate keys resolve to the highest index
        ifa.lut = {7'h33, 32'hAAAA_AAAA, 7'h33, 32'h5555_5555, 7'h01, 32'h1};
        ifa.key = 7'h33; #1;
        check("a_dup_out", ifa.out, 32'hAAAA_AAAA);
        check("a_dup_idx", ifa.hit_idx, 2);
        check("a_dup_hit", ifa.hit, 1);

        // registered path: release, hold with en=0, recapture
        ifa.lut = {7'b0010111, 32'h8000_0000, 7'b0110111, 32'h0, 7'b1101111, 32'h8000_0000};
        ifa.key = 7'b0110111;
        rst_a = 1'b0;
        tick();
        check("a_cap_out_q", ifa.out_q, 0);
        check("a_cap_hit_q", ifa.hit_q, 1);
        check("a_cap_idx_q", ifa.idx_q, 1);
        ifa.en = 1'b0; ifa.key = 7'b0010011;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("a_hold_out_q", ifa.out_q, 0);
            check("a_hold_hit_q", ifa.hit_q, 1);
            check("a_hold_idx_q", ifa.idx_q, 1);
        end
        ifa.en = 1'b1;
        tick();
        check("a_dflt_out_q", ifa.out_q, 32'h1234_5678);
        check("a_dflt_hit_q", ifa.hit_q, 0);
        check("a_dflt_idx_q", ifa.idx_q, 0);

        // mid-stream reset with a matching key and en=1
        ifa.key = 7'b0010111; rst_a = 1'b1; #1;
        check("a_mrst_out_pre", ifa.out, 32'h8000_0000);
        tick();
        check("a_mrst_out_q", ifa.out_q, 0);
        check("a_mrst_hit_q", ifa.hit_q, 0);
        check("a_mrst_out", ifa.out, 32'h8000_0000);
        check("a_mrst_hit", ifa.hit, 1);
        rst_a = 1'b0;
        tick();
        check("a_post_out_q", ifa.out_q, 32'h8000_0000);
        check("a_post_idx_q", ifa.idx_q, 2);

        // single pair: zero key and zero data are a real hit
        check("c_zero_out", ifc.out, 0);
        check("c_zero_hit", ifc.hit, 1);
        check("c_zero_idx", ifc.hit_idx, 0);
        ifc.key = 2'b01; #1;
        check("c_miss_out", ifc.out, 4'hA);
        check("c_miss_hit", ifc.hit, 0);
        check("c_miss_idx", ifc.hit_idx, 0);

        // randomized run on the 4-entry, 3-bit-key table
        rst_b = 1'b0;
        reg_model = '0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            ifb.key         = 3'($urandom_range(0, 7));
            ifb.lut         = 44'({$urandom, $urandom});
            ifb.default_out = 8'($urandom);
            ifb.en          = 1'($urandom_range(0, 1));
            rst_b           = ($urandom_range(0, 31) == 0);
            #1;
            m = model_b(ifb.lut, ifb.key, ifb.default_out);
            check("b_out", ifb.out, m[7:0]);
            check("b_hit", ifb.hit, m[10]);
            check("b_idx", ifb.hit_idx, m[9:8]);
            if (rst_b) reg_model = '0;
            else if (ifb.en) reg_model = m;
            exp_q.push_back(reg_model);
            tick();
            got = exp_q.pop_front();
            check("b_out_q", ifb.out_q, got[7:0]);
            check("b_hit_q", ifb.hit_q, got[10]);
            check("b_idx_q", ifb.idx_q, got[9:8]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mux_key_with_default.md
Name: mux_key_with_default

Overview:
- Parameterised key-lookup multiplexer: selects the data word paired with a matching key from a packed lookup table, or a default word if no key matches.
- Used by the execute stage to pick ALU operands and results by opcode.
- Combinational path (`out`) has zero latency for in-cycle use.
- Optional registered copy (`out_q`, `hit_q`, `idx_q`) serves pipelined consumers.

Parameters:
- NR_KEY, 2, number of key/data pairs in the table (>=1).
- KEY_LEN, 1, width of each key and of the `key` input in bits.
- DATA_LEN, 1, width of each data word, `default_out` and `out` in bits.

Ports:
- clk  input  1  clock; all registers update on the rising edge.
- rst  input  1  synchronous, active-high reset.
- key  input  KEY_LEN  lookup key.
- default_out  input  DATA_LEN  value driven when no table key matches.
- lut  input  NR_KEY*(KEY_LEN+DATA_LEN)  packed table of {key, data} pairs.
- en  input  1  capture enable for the registered outputs.
- out  output  DATA_LEN  combinational selected value.
- hit  output  1  combinational; 1 when at least one table key equals `key`.
- hit_idx  output  $clog2(NR_KEY) (min 1)  combinational index of the winning pair; 0 when `hit`=0.
- out_q  output  DATA_LEN  registered `out`.
- hit_q  output  1  registered `hit`.
- idx_q  output  $clog2(NR_KEY) (min 1)  registered `hit_idx`.

Behaviour:
- Pair layout: PAIR_LEN = KEY_LEN+DATA_LEN.
  - Pair i occupies lut[PAIR_LEN*(i+1)-1 : PAIR_LEN*i].
  - Within a pair, the key is the upper KEY_LEN bits and the data is the lower DATA_LEN bits.
  - The pair written first in a concatenation {k,d, k,d, ...} is therefore index NR_KEY-1.
- Match: pair i matches when its key equals `key` on every bit. Comparison is exact; no wildcards.
- Winner on multiple matches: the highest index wins, i.e. the pair listed first in the concatenation. Duplicate keys are legal and must not OR data together.
- Combinational outputs:
  - `out` = data of the winning pair if `hit`, else `default_out`.
  - `hit` = OR of all matches.
  - `hit_idx` = winning index, 0 when no hit.
  - All are purely combinational in `key`, `lut` and `default_out`, with no dependence on clk, rst or en.
  - No latches; no X propagation when inputs are known.
- Registered outputs:
  - On a rising clk edge with rst=1: `out_q`=0, `hit_q`=0, `idx_q`=0, regardless of `en`.
  - Else with en=1: `out_q`<=`out`, `hit_q`<=`hit`, `idx_q`<=`hit_idx`. Latency is one cycle.
  - Else: hold.
  - Reset asserted mid-stream clears the registers at that edge. The first capture after deassertion happens on the first edge with rst=0 and en=1.
- Boundary cases:
  - NR_KEY=1: the index width is 1 and `hit_idx` is always 0.
  - Data value 0 in a matching pair must yield `out`=0, not the default.
  - A key of all zeros is a valid key.

Test Plan:
- NR_KEY=3, KEY_LEN=7, DATA_LEN=32; lut={7'b0010111,32'h8000_0000, 7'b0110111,32'h0, 7'b1101111,32'h8000_0000}; default_out=32'h1234_5678.
  - key=7'b0110111 -> out=0, hit=1, hit_idx=1.
  - key=7'b0010011 -> out=32'h1234_5678, hit=0, hit_idx=0.
- Same table, key=7'b0010111 -> hit_idx=2, out=32'h8000_0000.
  - key=7'b1101111 -> hit_idx=0, out=32'h8000_0000.
- Duplicate keys: lut={7'h33,32'hAAAA_AAAA, 7'h33,32'h5555_5555, 7'h01,32'h1}; key=7'h33 -> out=32'hAAAA_AAAA (not 32'hFFFF_FFFF), hit_idx=2.
- Registered path, key=7'b0110111, en=1:
  - Hold rst=1 for 2 edges -> out_q=0, hit_q=0, idx_q=0.
  - Release rst -> after 1 edge out_q=0, hit_q=1, idx_q=1.
  - Change key to an unmatched value with en=0 -> out_q/hit_q/idx_q hold for 3 edges.
  - Set en=1 -> next edge out_q=default_out, hit_q=0.
- Assert rst together with en=1 and a matching key -> out_q=0, hit_q=0 at that edge; the combinational `out` stays correct throughout.
- Randomised: 1000 cycles of random key, lut and default_out for NR_KEY=4, KEY_LEN=3 (forces frequent duplicates).
  - `out` and `hit_idx` match a highest-index-wins golden model every cycle.
  - `out_q` equals the previous cycle's `out` whenever en=1 and rst=0.
